dataless_eager_fork: RTL

- Dataless eager fork that replicates one incoming handshake token onto SIZE output channels.
- Sits directly downstream of a dataless DVR slot chain and consumes its output channel.
- Each output fires independently as soon as its consumer is ready.
- The input token is released only when every output has accepted it, in the same or an earlier cycle.

---
 rtl/dataless_eager_fork_register_block.sv | 28 ++
 rtl/dataless_eager_fork.sv | 39 +++
 2 files changed

// File: rtl/dataless_eager_fork_register_block.sv
// One fork leg: remembers whether its output already took the current token.
// Zero-latency valid/done; a leg that has fired ignores its ready until the input transfers.
module eager_fork_register_block (
  input  logic clk,
  input  logic rst,
  input  logic ins_valid,
  input  logic outs_ready,
  input  logic ins_transfer,
  output logic outs_valid,
  output logic done
);

  logic sent;

  assign outs_valid = ins_valid & ~sent;
  assign done       = sent | outs_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sent <= 1'b0;
    end else if (ins_transfer) begin
      sent <= 1'b0;
    end else if (outs_valid && outs_ready) begin
      sent <= 1'b1;
    end
  end

endmodule

// File: rtl/dataless_eager_fork.sv
// Eager fork: one dataless input token copied to SIZE outputs, each firing as soon as ready.
// Zero latency; input stalls until every output has accepted, ins_ready is combinational in outs_ready.
module dataless_eager_fork #(
  parameter int SIZE = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ins_valid,
  output logic            ins_ready,
  output logic [SIZE-1:0] outs_valid,
  input  logic [SIZE-1:0] outs_ready
);

  logic [SIZE-1:0] done;
  logic            ins_transfer;

  generate
    if (SIZE < 2 || SIZE > 32) begin : g_bad_size
      $error("dataless_eager_fork: SIZE must be in 2..32");
    end
  endgenerate

  // ins_ready only looks at done, keeping ins_valid out of the ready path.
  assign ins_ready    = &done;
  assign ins_transfer = ins_valid & ins_ready;

  for (genvar i = 0; i < SIZE; i++) begin : g_leg
    eager_fork_register_block u_leg (
      .clk          (clk),
      .rst          (rst),
      .ins_valid    (ins_valid),
      .outs_ready   (outs_ready[i]),
      .ins_transfer (ins_transfer),
      .outs_valid   (outs_valid[i]),
      .done         (done[i])
    );
  end

endmodule
